data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the pipeline's data-memory port. Serves single-word reads
//  (combinational) and sized byte writes from the MEM stage. Serves 256-bit cache-block
//  read/write requests through a latency-timed valid handshake. Sits opposite the CPU top,
//  driving data_read_fDM, block_read_fDM and the block valid strobes.
// PARAMETERS
//  DEPTH_WORDS  4096  storage size in 32-bit words (power of 2); word index = addr[ADDR_W+1:2], wraps modulo depth
//  BLK_LATENCY  4     cycles from block-request accept edge to valid pulse; legal range 1..255
// PORTS
//  CLK                    in   1    single clock, rising edge
//  RESET                  in   1    asynchronous, active-low reset
//  data_address_2DM       in   32   byte address, word and block ops
//  MemRead_2DM            in   1    word read enable
//  MemWrite_2DM           in   1    word write enable
//  data_write_2DM         in   32   write data, right-justified
//  data_write_size_2DM    in   2    bytes to write: 1,2,3; 0 = 4
//  data_read_fDM          out  32   word read data
//  dBlkRead               in   1    block read request, held until valid
//  dBlkWrite              in   1    block write request, held until valid
//  block_write_2DM        in   256  block write data; word i at [32i+31:32i]
//  block_read_fDM         out  256  block read data, same packing
//  block_read_fDM_valid   out  1    one-cycle pulse: read block ready
//  block_write_fDM_valid  out  1    one-cycle pulse: write block committed
// BEHAVIOUR
//  Reset (RESET=0, async): FSM->IDLE, counter=0, block_read_fDM=0, both valids=0.
//  Storage array is not cleared by reset.
//  Word read: data_read_fDM = mem[idx] combinationally while MemRead_2DM=1, else 0. Zero latency.
//  Word write: on CLK edge with MemWrite_2DM=1.
//   - Big-endian byte lanes; byte lane k = addr[1:0]+j.
//   - Size n writes the low n bytes of data_write_2DM, MS byte first, at lanes addr[1:0]..addr[1:0]+n-1.
//   - Lanes past 3 are dropped (no wrap into next word).
//   - Size 0 writes the full word and ignores addr[1:0].
//  Simultaneous MemRead & MemWrite, same word: read returns the pre-edge value.
//  Block address: base = addr with [4:0] ignored; word i = base + 4i.
//  FSM IDLE -> BUSY -> ACK -> IDLE:
//   IDLE: if dBlkWrite, latch op=WR, base, block_write_2DM.
//         else if dBlkRead, latch op=RD, base.
//         Write has priority. Load cnt = BLK_LATENCY-1 and go to BUSY.
//   BUSY: if the latched request line drops, abort -> IDLE (no commit, no pulse).
//         else if cnt==0 -> ACK; else cnt--.
//         BLK_LATENCY=1: BUSY lasts one cycle.
//   ACK (one cycle): the relevant valid is high.
//         RD: block_read_fDM holds the 8 words sampled on the BUSY->ACK edge.
//         WR: all 8 words are written on the BUSY->ACK edge using the latched data.
//         Requests are ignored in ACK; the next accept is earliest in the following IDLE cycle.
//  Latency: valid is high in cycle accept+BLK_LATENCY+1 when the accept edge is counted as cycle 0+1.
//   Equivalently, valid is seen BLK_LATENCY+1 edges after the request was first sampled in IDLE.
//  block_read_fDM holds its last value outside ACK (it is not re-zeroed).
//  Word writes during BUSY to the pending block:
//   - RD sees the word value at the BUSY->ACK edge.
//   - WR block commit overwrites them (block commit wins on the same edge).
//  Reset asserted mid-BUSY: request dropped, no partial commit, outputs at reset values.
// STRUCTURE
//  Package dm_pkg:
//   - state enum {IDLE,BUSY,ACK}
//   - BLK_WORDS=8, BLK_BITS=256
//   - SZ_WORD=2'd0 encoding
//   - function blk_base(addr)
//  Sub-module dm_byte_merge (combinational): old word, data, addr[1:0], size -> merged word.
//  Top: array + FSM + latency counter.
// TESTING
//  1. Write 0xDEADBEEF size 0 @0x100, read @0x100 -> 0xDEADBEEF; MemRead=0 -> data_read_fDM=0.
//  2. Word 0x11223344 @0x200, then write 0x000000AA size 1 @0x202 -> read 0x1122AA44.
//     Then size 2, 0xBBCC @0x203 -> 0x1122AABB (lane overflow dropped).
//  3. BLK_LATENCY=4, dBlkRead @0x40 held -> block_read_fDM_valid high for exactly 1 cycle, 5 edges after first sample.
//     Data word i = mem[0x40+4i].
//  4. dBlkRead and dBlkWrite together, addr 0x80 -> write served first, block_write_fDM_valid pulses, mem[0x80..0x9C] updated.
//     Held read then served after an IDLE cycle and returns the new data.
//  5. dBlkWrite dropped in BUSY -> no valid pulse, memory unchanged.
//     RESET low mid-BUSY -> valids 0, FSM IDLE, memory unchanged.
//  6. Address 0x40 + DEPTH_WORDS*4 aliases word 0x40; block at same alias matches test 3 data.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types, constants and helpers for the data-memory responder
package dm_pkg;

  // Block handshake sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } dm_state_e;

  // Kind of block request latched at accept time.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } dm_op_e;

  localparam int         BLK_WORDS = 8;
  localparam int         BLK_BITS  = 256;
  localparam logic [1:0] SZ_WORD   = 2'd0;

  // Cache blocks are 32-byte aligned; the low five address bits never matter.
  function automatic logic [31:0] blk_base(input logic [31:0] addr);
    return {addr[31:5], 5'b0_0000};
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// rtl/dm_byte_merge.sv - big-endian sized byte merge of write data into an existing word
//
// Ports:
//   old_word_i  current memory word
//   data_i      right-justified write data
//   lane_i      starting byte lane (address bits [1:0]); lane 0 is bits [31:24]
//   size_i      bytes to write, 1..3, 0 means the whole word
//   merged_o    resulting word
module dm_byte_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  output logic [31:0] merged_o
);

  logic [2:0]  nbytes;
  logic [1:0]  lane;
  logic [5:0]  lsh;
  logic [5:0]  rsh;
  logic [31:0] mask;
  logic [31:0] src;

  // A full-word write ignores the lane offset entirely.
  assign nbytes = (size_i == SZ_WORD) ? 3'd4 : {1'b0, size_i};
  assign lane   = (size_i == SZ_WORD) ? 2'd0 : lane_i;

  // Left-align the low n data bytes to lane 0, then slide right to the start
  // lane. Bytes shifted past lane 3 fall off, which is the desired drop.
  assign lsh  = {3'd4 - nbytes, 3'b000};
  assign rsh  = {1'b0, lane, 3'b000};
  assign mask = (32'hFFFF_FFFF << lsh) >> rsh;
  assign src  = (data_i << lsh) >> rsh;

  assign merged_o = (old_word_i & ~mask) | (src & mask);

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder: word read/write plus timed 256-bit block transfers
//
// Ports:
//   CLK, RESET              clock (rising edge), asynchronous active-low reset
//   data_address_2DM        byte address for word and block operations
//   MemRead_2DM             word read enable; data_read_fDM is combinational
//   MemWrite_2DM            word write enable with data_write_2DM / data_write_size_2DM
//   dBlkRead, dBlkWrite     block requests, held by the requester until its valid pulse
//   block_write_2DM         block write data, word i at [32i+31:32i]
//   block_read_fDM          block read data, held between reads
//   block_read_fDM_valid    one-cycle pulse when a read block is ready
//   block_write_fDM_valid   one-cycle pulse when a write block has been committed
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int BLK_LATENCY = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         data_address_2DM,
  input  logic                MemRead_2DM,
  input  logic                MemWrite_2DM,
  input  logic [31:0]         data_write_2DM,
  input  logic [1:0]          data_write_size_2DM,
  output logic [31:0]         data_read_fDM,
  input  logic                dBlkRead,
  input  logic                dBlkWrite,
  input  logic [BLK_BITS-1:0] block_write_2DM,
  output logic [BLK_BITS-1:0] block_read_fDM,
  output logic                block_read_fDM_valid,
  output logic                block_write_fDM_valid
);

  localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
  localparam logic [7:0] CNT_LOAD = 8'(BLK_LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         word_old;
  logic [31:0]         word_merged;
  logic [31:0]         blk_addr;
  logic [ADDR_W-1:0]   blk_idx;

  dm_state_e           state_q, state_d;
  dm_op_e              op_q, op_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [BLK_BITS-1:0] wdata_q, wdata_d;
  logic [BLK_BITS-1:0] rdata_q, rdata_d;
  logic [BLK_BITS-1:0] blk_words;
  logic                req_held;
  logic                blk_commit;
  logic                blk_sample;
  logic                unused_addr_bits;

  // Word path: index wraps modulo depth by simply dropping upper address bits.
  assign word_idx      = data_address_2DM[ADDR_W+1:2];
  assign word_old      = mem[word_idx];
  assign data_read_fDM = MemRead_2DM ? word_old : 32'h0;

  assign blk_addr = blk_base(data_address_2DM);
  assign blk_idx  = blk_addr[ADDR_W+1:2];

  assign unused_addr_bits = ^{data_address_2DM[31:ADDR_W+2], blk_addr[31:ADDR_W+2], blk_addr[1:0]};

  dm_byte_merge u_merge (
    .old_word_i (word_old),
    .data_i     (data_write_2DM),
    .lane_i     (data_address_2DM[1:0]),
    .size_i     (data_write_size_2DM),
    .merged_o   (word_merged)
  );

  // Gather the pending block straight from the array so a read captures any
  // word writes that landed while the request was in BUSY.
  always_comb begin
    blk_words = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
      blk_words[32*i +: 32] = mem[base_q + ADDR_W'(i)];
    end
  end

  // Storage is deliberately not reset. The block commit is issued after the
  // word write so it wins when both target the same word on one edge.
  always_ff @(posedge CLK) begin
    if (MemWrite_2DM) begin
      mem[word_idx] <= word_merged;
    end
    if (blk_commit) begin
      for (int i = 0; i < BLK_WORDS; i++) begin
        mem[base_q + ADDR_W'(i)] <= wdata_q[32*i +: 32];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= 8'd0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    blk_commit = 1'b0;
    blk_sample = 1'b0;
    req_held   = (op_q == OP_WR) ? dBlkWrite : dBlkRead;

    unique case (state_q)
      IDLE: begin
        if (dBlkWrite) begin
          op_d    = OP_WR;
          base_d  = blk_idx;
          wdata_d = block_write_2DM;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end else if (dBlkRead) begin
          op_d    = OP_RD;
          base_d  = blk_idx;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A withdrawn request is abandoned without touching memory.
        if (!req_held) begin
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = ACK;
          if (op_q == OP_WR) begin
            blk_commit = 1'b1;
          end else begin
            blk_sample = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (blk_sample) begin
      rdata_d = blk_words;
    end
  end

  assign block_read_fDM        = rdata_q;
  assign block_read_fDM_valid  = (state_q == ACK) && (op_q == OP_RD);
  assign block_write_fDM_valid = (state_q == ACK) && (op_q == OP_WR);

endmodule
